// File: rtl/and3_resp_checker.sv
// rtl/and3_resp_checker.sv - response checker for a 3-input AND device under check
//
// Purpose
//   Arms on a start pulse, then accepts stimulus vectors {a,b,c} one at a time.
//   For each accepted vector it waits SETTLE clocks and samples the device
//   responses d/e. It compares them against the golden values:
//     d_exp = a&b&c
//     e_exp = ~(a&b&c)
//   The golden values come from the latched vector, not the live inputs.
//   A run completes (DONE) once every one of the eight vectors has been checked
//   at least once.
//
// Parameters
//   SETTLE  clocks from vector acceptance to response sample (1..15)
//   ERR_W   width of the saturating mismatch counter
//
// Ports
//   clk            in   sole clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   start          in   one-cycle pulse arming a new run (from IDLE or DONE)
//   vld            in   one-cycle strobe, new vector on a/b/c this cycle
//   a, b, c        in   stimulus bits driven to the device under check
//   d, e           in   device responses
//   busy           out  run in progress (ARMED or WAIT)
//   done           out  all eight vectors checked
//   pass           out  done with no mismatches and no overrun
//   err_cnt        out  saturating count of mismatching samples
//   cov            out  bit {a,b,c} set once that vector has been checked
//   overrun        out  sticky: a vector strobe arrived while waiting to sample
//   first_err_idx  out  vector of the first mismatch in the run
//
// Configuration
//   AND3_FIRST_ERR_EN  when defined, first_err_idx captures the first
//                      mismatching vector. Otherwise it is tied to zero and no
//                      capture state exists.

module and3_resp_checker #(
  parameter int unsigned SETTLE = 2,
  parameter int unsigned ERR_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vld,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       cov,
  output logic             overrun,
  output logic [2:0]       first_err_idx
);

  localparam int unsigned      CNT_W       = 4;
  // The counter is loaded with SETTLE-1 on acceptance, so the compare happens
  // on the SETTLE-th edge after the accepting edge.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q,  state_d;
  logic [2:0]       vec_q,    vec_d;
  logic [CNT_W-1:0] settle_q, settle_d;
  logic [ERR_W-1:0] err_q,    err_d;
  logic [7:0]       cov_q,    cov_d;
  logic             ovr_q,    ovr_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic             pass_q,   pass_d;

  logic       run_start;
  logic       compare_now;
  logic       gold_d;
  logic       gold_e;
  logic       mismatch;
  logic [7:0] vec_onehot;

  // Start is only honoured outside a run; in IDLE it also swallows a
  // coincident vld because ARMED is not reached until this edge.
  assign run_start   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign compare_now = (state_q == S_WAIT) && (settle_q == '0);

  assign gold_d     = vec_q[2] & vec_q[1] & vec_q[0];
  assign gold_e     = ~gold_d;
  assign mismatch   = (d != gold_d) || (e != gold_e);
  assign vec_onehot = 8'b0000_0001 << vec_q;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    settle_d = settle_q;
    err_d    = err_q;
    cov_d    = cov_q;
    ovr_d    = ovr_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (run_start) begin
          state_d = S_ARMED;
          err_d   = '0;
          cov_d   = '0;
          ovr_d   = 1'b0;
        end
      end

      S_ARMED: begin
        if (vld) begin
          vec_d    = {a, b, c};
          settle_d = SETTLE_LOAD;
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        // Any strobe while a vector is in flight is dropped and flagged,
        // including one arriving on the compare edge itself.
        if (vld) begin
          ovr_d = 1'b1;
        end
        if (!compare_now) begin
          settle_d = settle_q - 1'b1;
        end else begin
          cov_d = cov_q | vec_onehot;
          if (mismatch && (err_q != ERR_MAX)) begin
            err_d = err_q + 1'b1;
          end
          state_d = (cov_d == 8'hFF) ? S_DONE : S_ARMED;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Status flags are decoded from the next state so they come straight
    // out of flops with no path from the inputs.
    busy_d = (state_d == S_ARMED) || (state_d == S_WAIT);
    done_d = (state_d == S_DONE);
    pass_d = done_d && (err_d == '0) && !ovr_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      vec_q    <= '0;
      settle_q <= '0;
      err_q    <= '0;
      cov_q    <= '0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      cov_q    <= cov_d;
      ovr_q    <= ovr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign pass    = pass_q;
  assign err_cnt = err_q;
  assign cov     = cov_q;
  assign overrun = ovr_q;

`ifdef AND3_FIRST_ERR_EN
  logic       first_seen_q;
  logic [2:0] first_idx_q;
  logic       err_event;

  assign err_event = compare_now && mismatch;

  // Only the first mismatch of a run is recorded; later ones leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_seen_q <= 1'b0;
      first_idx_q  <= 3'b000;
    end else if (run_start) begin
      first_seen_q <= 1'b0;
      first_idx_q  <= 3'b000;
    end else if (err_event && !first_seen_q) begin
      first_seen_q <= 1'b1;
      first_idx_q  <= vec_q;
    end
  end

  assign first_err_idx = first_idx_q;
`else
  assign first_err_idx = 3'b000;
`endif

endmodule

// File: tb/tb_and3_resp_checker.sv
// tb/tb_and3_resp_checker.sv - scoreboard bench for and3_resp_checker

module tb_and3_resp_checker;

  localparam int SETTLE  = 2;
  localparam int ERR_W   = 2;
  localparam int ERR_MAX = (1 << ERR_W) - 1;

  logic             clk   = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             vld   = 1'b0;
  logic             a = 1'b0, b = 1'b0, c = 1'b0;
  logic             d = 1'b0, e = 1'b1;
  logic             busy, done, pass, overrun;
  logic [ERR_W-1:0] err_cnt;
  logic [7:0]       cov;
  logic [2:0]       first_err_idx;

  and3_resp_checker #(.SETTLE(SETTLE), .ERR_W(ERR_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vld(vld),
    .a(a), .b(b), .c(c), .d(d), .e(e),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .cov(cov), .overrun(overrun), .first_err_idx(first_err_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         pass;
    int         err;
    logic [7:0] cov;
    bit         ovr;
    logic [2:0] first;
  } result_t;

  result_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: run flag, time stamp of the pending sample, coverage set.
  bit         m_run  = 0;
  bit         m_done = 0;
  int         m_due  = -1;
  logic [2:0] m_vec  = 3'b000;
  logic [7:0] m_cov  = 8'h00;
  int         m_err  = 0;
  bit         m_ovr  = 0;
  bit         m_seen = 0;
  logic [2:0] m_first = 3'b000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [2:0] exp_first();
`ifdef AND3_FIRST_ERR_EN
    return m_first;
`else
    return 3'b000;
`endif
  endfunction

  task automatic model_reset();
    m_run = 0; m_done = 0; m_due = -1; m_vec = 3'b000; m_cov = 8'h00;
    m_err = 0; m_ovr = 0; m_seen = 0; m_first = 3'b000;
  endtask

  task automatic model_step();
    result_t r;
    bit      golden;
    cyc++;
    if (m_due >= 0) begin
      if (vld) m_ovr = 1;
      if (cyc == m_due) begin
        golden = (m_vec == 3'b111);
        m_cov[m_vec] = 1'b1;
        if (d !== golden || e !== !golden) begin
          if (!m_seen) begin
            m_seen  = 1;
            m_first = m_vec;
          end
          if (m_err < ERR_MAX) m_err++;
        end
        m_due = -1;
        if (m_cov == 8'hFF) begin
          m_run  = 0;
          m_done = 1;
          r.cyc = cyc; r.pass = (m_err == 0) && !m_ovr; r.err = m_err;
          r.cov = m_cov; r.ovr = m_ovr; r.first = exp_first();
          exp_q.push_back(r);
        end
      end
    end else if (m_run) begin
      if (vld) begin
        m_vec = {a, b, c};
        m_due = cyc + SETTLE;
      end
    end else if (start) begin
      model_reset();
      m_run = 1;
    end
  endtask

  // Device-under-check response: 0 correct, 1 d stuck at 0, 2 e inverted.
  function automatic logic [1:0] resp(input logic [2:0] v, input int mode, input bit glitch);
    logic dd, ee;
    dd = (v == 3'b111);
    ee = !dd;
    case (mode)
      1: dd = 1'b0;
      2: ee = (v == 3'b111);
      default: ;
    endcase
    if (glitch) dd = !dd;
    return {dd, ee};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic apply(input logic [2:0] v, input int mode, input bit glitch, input int gap);
    {a, b, c} = v;
    {d, e}    = resp(v, mode, glitch);
    vld = 1'b1;
    tick();
    vld = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic sweep(input int mode, input int gap);
    for (int v = 0; v < 8; v++) apply(3'(v), mode, 1'b0, gap);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  // Monitor: compares live outputs against the model every cycle and pops
  // the scoreboard whenever the DUT raises done.
  initial begin
    bit         prev_done;
    result_t    r;
    logic [31:0] act, exp;
    prev_done = 0;
    forever begin
      @(negedge clk);
      act = {13'd0, busy, done, pass, overrun, first_err_idx, 4'(err_cnt), cov};
      exp = {13'd0, m_run, m_done, m_done && (m_err == 0) && !m_ovr, m_ovr,
             exp_first(), 4'(m_err), m_cov};
      chk("live_state", act, exp);
      if (done === 1'b1 && !prev_done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          r = exp_q.pop_front();
          chk("done_cycle", cyc, r.cyc);
          chk("done_pass", {31'd0, pass}, {31'd0, r.pass});
          chk("done_err_cnt", 32'(err_cnt), r.err);
          chk("done_cov", {24'd0, cov}, {24'd0, r.cov});
          chk("done_overrun", {31'd0, overrun}, {31'd0, r.ovr});
          chk("done_first_idx", {29'd0, first_err_idx}, {29'd0, r.first});
        end
      end
      prev_done = (done === 1'b1);
    end
  end

  initial begin
    logic [2:0] v;
    repeat (3) tick();
    chk("reset_state", {busy, done, pass, overrun, first_err_idx, 4'(err_cnt), cov}, 32'd0);
    rst_n = 1'b1;
    tick();

    // vld in IDLE is ignored, then start+vld together drops the vld.
    apply(3'b011, 0, 1'b0, 3);
    {a, b, c} = 3'b101;
    start = 1'b1; vld = 1'b1;
    tick();
    start = 1'b0; vld = 1'b0;
    repeat (4) tick();
    chk("start_vld_busy", {31'd0, busy}, 32'd1);
    chk("start_vld_cov", {24'd0, cov}, 32'd0);

    // Clean sweep with an ignored start in the middle.
    for (int i = 0; i < 8; i++) begin
      apply(3'(i), 0, 1'b0, 20);
      if (i == 3) pulse_start();
    end
    wait_done();
    chk("clean_pass", {31'd0, pass}, 32'd1);

    // vld in DONE ignored; restart from DONE with d stuck at 0.
    apply(3'b111, 2, 1'b0, 3);
    pulse_start();
    sweep(1, 20);
    wait_done();
    chk("stuck_err", 32'(err_cnt), 32'd1);
    chk("stuck_pass", {31'd0, pass}, 32'd0);
`ifdef AND3_FIRST_ERR_EN
    chk("stuck_first", {29'd0, first_err_idx}, 32'd7);
`endif

    // e inverted: every vector mismatches, counter saturates.
    pulse_start();
    sweep(2, 20);
    wait_done();
    chk("sat_err", 32'(err_cnt), 32'd3);

    // Overrun: second vld one cycle after the first.
    pulse_start();
    apply(3'b010, 0, 1'b0, 0);
    apply(3'b011, 0, 1'b0, 1);
    chk("ovr_cov", {24'd0, cov}, 32'h04);
    chk("ovr_flag", {31'd0, overrun}, 32'd1);
    for (int i = 0; i < 8; i++) if (i != 2) apply(3'(i), 0, 1'b0, 20);
    wait_done();
    chk("ovr_pass", {31'd0, pass}, 32'd0);

    // Reset during WAIT after four vectors.
    pulse_start();
    for (int i = 0; i < 4; i++) apply(3'(i), 0, 1'b0, 20);
    apply(3'b100, 0, 1'b0, 0);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset", {busy, done, pass, overrun, first_err_idx, 4'(err_cnt), cov}, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("after_reset_idle", {31'd0, busy}, 32'd0);
    pulse_start();
    sweep(0, 20);
    wait_done();
    chk("reset_restart_pass", {31'd0, pass}, 32'd1);

    // 101 applied twice, glitch on the second application only.
    pulse_start();
    for (int i = 0; i < 6; i++) apply(3'(i), 0, 1'b0, 20);
    apply(3'b101, 0, 1'b1, 20);
    apply(3'b110, 0, 1'b0, 20);
    apply(3'b111, 0, 1'b0, 20);
    wait_done();
    chk("repeat_err", 32'(err_cnt), 32'd1);
    chk("repeat_cov", {24'd0, cov}, 32'hFF);

    // Randomized runs: random vectors, faults, gaps and stray starts,
    // then a clean sweep so every run completes.
    for (int run = 0; run < 6; run++) begin
      pulse_start();
      for (int j = 0; j < 12; j++) begin
        v = 3'($urandom_range(0, 7));
        apply(v, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0,
              ($urandom_range(0, 7) == 0), int'($urandom_range(0, 4)));
        if ($urandom_range(0, 9) == 0) pulse_start();
      end
      sweep(0, SETTLE + 1);
      wait_done();
    end

    repeat (2) tick();
    chk("scoreboard_drain", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/and3_resp_checker.md
AND3_RESP_CHECKER -- requirements
Module: and3_resp_checker

Interface
REQ-001 Parameter SETTLE, default 2: clock cycles from vector acceptance to response sample; legal range 1..15.
REQ-002 Parameter ERR_W, default 4: width of the mismatch counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse that arms a new check run.
REQ-006 vld  input  1  one-cycle strobe: a new stimulus vector is applied on a/b/c this cycle.
REQ-007 a, b, c  input  1 each  stimulus bits driven to the DUT.
REQ-008 d, e  input  1 each  DUT responses.
REQ-009 busy  output  1  high in ARMED and WAIT.
REQ-010 done  output  1  high in DONE.
REQ-011 pass  output  1  valid while done; 1 when err_cnt==0 and no overrun.
REQ-012 err_cnt  output  ERR_W  saturating count of mismatching samples.
REQ-013 cov  output  8  bit {a,b,c} set once that vector has been checked.
REQ-014 overrun  output  1  sticky; vld arrived while in WAIT.
REQ-015 first_err_idx  output  3  {a,b,c} of the first mismatching vector (only with AND3_FIRST_ERR_EN).

Function
REQ-016 Golden model SHALL be d_exp = a&b&c, e_exp = ~(a&b&c).
REQ-017 FSM states SHALL be IDLE, ARMED, WAIT, DONE.
REQ-018 IDLE -> ARMED on start; entry clears err_cnt, cov, overrun and first-error state.
REQ-019 In ARMED, vld at edge k SHALL latch {a,b,c} into an internal vector register, load the settle counter, and go to WAIT.
REQ-020 In WAIT, d and e SHALL be sampled at edge k+SETTLE and compared with the golden values of the latched vector, not the live a/b/c.
REQ-021 On the compare edge, the cov bit for the latched vector SHALL be set; on a mismatch of d or e, err_cnt SHALL increment by 1, once per vector.
REQ-022 err_cnt SHALL saturate at 2^ERR_W-1.
REQ-023 After the compare edge, the FSM SHALL go to DONE if cov becomes 8'hFF, else return to ARMED.
REQ-024 A repeated vector SHALL be checked again (its errors count) without clearing its cov bit.
REQ-025 vld in WAIT SHALL be ignored for checking and SHALL set overrun.
REQ-026 vld in IDLE or DONE SHALL be ignored, with no flag.
REQ-027 start in ARMED or WAIT SHALL be ignored.
REQ-028 start in DONE SHALL restart as in REQ-018.
REQ-029 start and vld in the same IDLE cycle: only start acts; vld is dropped.
REQ-030 done, pass and busy SHALL be registered, decoded from state, with no combinational path from inputs.
REQ-031 pass SHALL be 0 whenever done is 0.

Reset
REQ-032 rst_n low SHALL force, asynchronously: state=IDLE, busy=0, done=0, pass=0, err_cnt=0, cov=0, overrun=0, first_err_idx=0, settle counter=0.
REQ-033 Reset mid-run SHALL discard all progress; a new start is required after release.

Configuration
REQ-034 Macro AND3_FIRST_ERR_EN SHALL control first-error capture.
REQ-035 With AND3_FIRST_ERR_EN defined: first_err_idx SHALL capture the latched vector on the first mismatch of a run, then hold until the next run start or reset.
REQ-036 Without AND3_FIRST_ERR_EN: first_err_idx SHALL be tied to 3'b000 and no capture logic is synthesized; all other behaviour is unchanged.

Verification
REQ-037 Correct DUT, start, then vectors 000..111 in order, each vld followed by 20 idle cycles -> done=1, pass=1, err_cnt=0, cov=8'hFF, overrun=0.
REQ-038 Faulty DUT with d stuck at 0, full sweep -> err_cnt=1, pass=0; with AND3_FIRST_ERR_EN, first_err_idx=3'b111.
REQ-039 SETTLE=2, vld for 010, then vld again 1 cycle later -> overrun=1, second vld not checked, cov=8'h04 after the compare edge.
REQ-040 e inverted (e=a&b&c), ERR_W=2, full sweep -> err_cnt saturates at 3, pass=0.
REQ-041 rst_n pulsed low during WAIT after 4 vectors -> all outputs 0 immediately; restart and full sweep -> pass=1.
REQ-042 Vector 101 applied twice during a sweep, with a DUT glitch on the second application only -> err_cnt=1, cov=8'hFF at done.
